// File: rtl/rv_hazard_unit.sv
// Pipeline hazard/control unit: operand bypass selects, load-use stall, pause, flush drain,
// stall watchdog and unsupported-instruction tracking. Optional perf counters: RV_HAZARD_PERF_EN.
module rv_hazard_unit #(
    parameter int unsigned NUM_RS    = 2,
    parameter int unsigned NUM_FWD   = 4,
    parameter int unsigned NUM_LD    = 2,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned FLUSH_LEN = 1,
    parameter int unsigned INV_DEPTH = 2,
    parameter int unsigned STALL_TMO = 255
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_pc_change,
    input  logic                        i_need_pause,
    input  logic                        i_dec_sup,
    input  logic [NUM_RS*REG_AW-1:0]    i_dec_rs,
    input  logic [NUM_RS*REG_AW-1:0]    i_exe_rs,
    input  logic [NUM_FWD*REG_AW-1:0]   i_fwd_rd,
    input  logic [NUM_FWD-1:0]          i_fwd_wr,
    input  logic [NUM_LD*REG_AW-1:0]    i_ld_rd,
    input  logic [NUM_LD-1:0]           i_ld_vld,
    output logic                        o_dec_flush,
    output logic                        o_dec_stall,
    output logic                        o_exe_flush,
    output logic [NUM_RS*NUM_FWD-1:0]   o_fwd_sel,
    output logic                        o_inv_inst,
    output logic                        o_stall_tmo,
    output logic [31:0]                 o_perf_stall,
    output logic [31:0]                 o_perf_flush
);

    localparam int unsigned FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int unsigned TCW = $clog2(STALL_TMO + 1);
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_LEN - 1);
    localparam logic [TCW-1:0] TMO_MAX      = TCW'(STALL_TMO);

    typedef enum logic [1:0] {StRun, StFlush, StStall} state_e;

    state_e                 state_q;
    logic [FCW-1:0]         flush_cnt_q;
    logic [TCW-1:0]         tmo_cnt_q;
    logic                   tmo_q;
    logic [INV_DEPTH-1:0]   sr_q;
    logic                   load_hz;
    logic                   dec_flush;
    logic                   dec_stall;

    // Bypass: lowest-index (youngest) matching producer wins; x0 is never forwarded.
    for (genvar k = 0; k < NUM_RS; k++) begin : g_fwd
        logic [REG_AW-1:0]  rs;
        logic [NUM_FWD-1:0] hit;
        assign rs = i_exe_rs[k*REG_AW +: REG_AW];
        for (genvar j = 0; j < NUM_FWD; j++) begin : g_src
            assign hit[j] = i_fwd_wr[j] && (rs != '0) && (rs == i_fwd_rd[j*REG_AW +: REG_AW]);
        end
        assign o_fwd_sel[k*NUM_FWD +: NUM_FWD] = hit & (~hit + NUM_FWD'(1));
    end

    always_comb begin
        load_hz = 1'b0;
        for (int m = 0; m < NUM_LD; m++) begin
            for (int k = 0; k < NUM_RS; k++) begin
                if (i_ld_vld[m] && (i_ld_rd[m*REG_AW +: REG_AW] != '0) &&
                    (i_ld_rd[m*REG_AW +: REG_AW] == i_dec_rs[k*REG_AW +: REG_AW])) begin
                    load_hz = 1'b1;
                end
            end
        end
    end

    assign dec_flush   = i_pc_change || (state_q == StFlush);
    assign dec_stall   = !dec_flush && (load_hz || i_need_pause);
    assign o_dec_flush = dec_flush;
    assign o_dec_stall = dec_stall;
    assign o_exe_flush = dec_flush || dec_stall;
    assign o_stall_tmo = tmo_q;
    assign o_inv_inst  = !sr_q[INV_DEPTH-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
        end else if (i_pc_change) begin
            if (FLUSH_LEN > 1) begin
                state_q     <= StFlush;
                flush_cnt_q <= FLUSH_RELOAD;
            end else begin
                state_q     <= StRun;
                flush_cnt_q <= '0;
            end
        end else if (state_q == StFlush) begin
            flush_cnt_q <= flush_cnt_q - FCW'(1);
            if (flush_cnt_q == FCW'(1)) begin
                state_q <= StRun;
            end
        end else if (load_hz || i_need_pause) begin
            state_q <= StStall;
        end else begin
            state_q <= StRun;
        end
    end

    // Flag sets on the edge that completes the STALL_TMO-th consecutive stall cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (dec_stall) begin
            if (tmo_cnt_q != TMO_MAX) begin
                tmo_cnt_q <= tmo_cnt_q + TCW'(1);
            end
            if (tmo_cnt_q == TMO_MAX - TCW'(1)) begin
                tmo_q <= 1'b1;
            end
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    if (INV_DEPTH == 1) begin : g_sr1
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sr_q <= '1;
            end else if (dec_flush) begin
                sr_q <= '1;
            end else if (!dec_stall) begin
                sr_q <= i_dec_sup;
            end
        end
    end else begin : g_srn
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sr_q <= '1;
            end else if (dec_flush) begin
                sr_q <= '1;
            end else if (!dec_stall) begin
                sr_q <= {sr_q[INV_DEPTH-2:0], i_dec_sup};
            end
        end
    end

`ifdef RV_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (dec_stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (i_pc_change && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign o_perf_stall = perf_stall_q;
    assign o_perf_flush = perf_flush_q;
`else
    assign o_perf_stall = '0;
    assign o_perf_flush = '0;
`endif

endmodule
